// File: rtl/mmm_pkg.sv
// rtl/mmm_pkg.sv - shared constants and helpers for the MMM input stream
package mmm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SEND_A = 2'd1;
  localparam state_t ST_SEND_B = 2'd2;
  localparam state_t ST_DRAIN  = 2'd3;

  localparam int TUSER_NEWB_BIT = 0;
  localparam int TUSER_K_LSB    = 1;

  function automatic int beat_count(input int k, input logic new_b, input int m, input int n);
    return m * k + (new_b ? k * n : 0);
  endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// rtl/axis_skid_fifo2.sv - 2-entry FIFO with registered head driving a stream output
module axis_skid_fifo2 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [1:0]   occupancy
);

  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;

  assign push     = s_tvalid;
  assign pop      = m_tvalid & m_tready;
  assign m_tvalid = (occupancy != 2'd0);

  // Head register is the output; the tail only ever holds the second entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= 2'd0;
      m_tdata   <= '0;
      tail_q    <= '0;
    end else begin
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
      case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) m_tdata <= s_tdata;
          else                   tail_q  <= s_tdata;
        end
        2'b01: m_tdata <= tail_q;
        2'b11: begin
          if (occupancy == 2'd1) begin
            m_tdata <= s_tdata;
          end else begin
            m_tdata <= tail_q;
            tail_q  <= s_tdata;
          end
        end
        default: ;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && occupancy == 2'd2));

endmodule

// File: rtl/mmm_stream_tx.sv
// rtl/mmm_stream_tx.sv - reads A (and optionally B) from memory and streams them out
module mmm_stream_tx
  import mmm_pkg::*;
#(
  parameter int INW  = 12,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS = $clog2(MAXK + 1),
  localparam int A_AW   = $clog2(M * MAXK),
  localparam int B_AW   = $clog2(MAXK * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [K_BITS-1:0] cmd_k,
  input  logic              cmd_new_b,
  output logic              cmd_err,
  output logic              busy,
  output logic [A_AW-1:0]   a_rd_addr,
  input  logic [INW-1:0]    a_rd_data,
  output logic [B_AW-1:0]   b_rd_addr,
  input  logic [INW-1:0]    b_rd_data,
  output logic [INW-1:0]    AXIS_TDATA,
  output logic              AXIS_TVALID,
  output logic [K_BITS:0]   AXIS_TUSER,
  input  logic              AXIS_TREADY
);

  localparam int CW = (A_AW > B_AW) ? A_AW : B_AW;

  state_t            state;
  logic [K_BITS:0]   tuser_q;
  logic [K_BITS-1:0] k_q;
  logic [CW-1:0]     idx;
  logic [CW-1:0]     a_last;
  logic [CW-1:0]     b_last;
  logic [A_AW-1:0]   a_addr_q;
  logic [B_AW-1:0]   b_addr_q;
  logic              in_flight;
  logic              in_flight_src;
  logic [1:0]        occupancy;
  logic [2:0]        pending;
  logic              cmd_fire;
  logic              k_bad;
  logic              pop;
  logic              issue;

  assign k_q    = tuser_q[TUSER_K_LSB +: K_BITS];
  assign a_last = CW'(M * int'(k_q) - 1);
  assign b_last = CW'(N * int'(k_q) - 1);

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign k_bad     = (cmd_k == '0) || (cmd_k > K_BITS'(MAXK));
  assign pop       = AXIS_TVALID & AXIS_TREADY;

  // Buffered plus in-flight entries after this cycle's pop must leave room for one more.
  assign pending = 3'(occupancy) + 3'(in_flight) - 3'(pop);
  assign issue   = ((state == ST_SEND_A) || (state == ST_SEND_B)) && (pending < 3'd2);

  assign a_rd_addr  = (issue && state == ST_SEND_A) ? idx[A_AW-1:0] : a_addr_q;
  assign b_rd_addr  = (issue && state == ST_SEND_B) ? idx[B_AW-1:0] : b_addr_q;
  assign AXIS_TUSER = tuser_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      tuser_q       <= '0;
      idx           <= '0;
      a_addr_q      <= '0;
      b_addr_q      <= '0;
      in_flight     <= 1'b0;
      in_flight_src <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      cmd_err       <= cmd_fire && k_bad;
      in_flight     <= issue;
      in_flight_src <= (state == ST_SEND_B);
      if (issue) begin
        if (state == ST_SEND_A) a_addr_q <= idx[A_AW-1:0];
        else                    b_addr_q <= idx[B_AW-1:0];
      end
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            tuser_q[TUSER_K_LSB +: K_BITS] <= cmd_k;
            tuser_q[TUSER_NEWB_BIT]        <= cmd_new_b;
            idx                            <= '0;
            if (!k_bad) state <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          if (issue) begin
            if (idx == a_last) begin
              idx   <= '0;
              state <= tuser_q[TUSER_NEWB_BIT] ? ST_SEND_B : ST_DRAIN;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        ST_SEND_B: begin
          if (issue) begin
            if (idx == b_last) begin
              idx   <= '0;
              state <= ST_DRAIN;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && occupancy == 2'd1 && !in_flight) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_fifo2 #(.W(INW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .s_tdata   (in_flight_src ? b_rd_data : a_rd_data),
    .s_tvalid  (in_flight),
    .m_tdata   (AXIS_TDATA),
    .m_tvalid  (AXIS_TVALID),
    .m_tready  (AXIS_TREADY),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_mmm_stream_tx.sv
// tb/tb_mmm_stream_tx.sv - self-checking bench for mmm_stream_tx
module tb_mmm_stream_tx;

  localparam int INW = 12, M = 7, N = 9, MAXK = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_new_b, cmd_err, busy;
  logic [3:0]  cmd_k;
  logic [5:0]  a_rd_addr;
  logic [6:0]  b_rd_addr;
  logic [11:0] a_rd_data, b_rd_data, AXIS_TDATA;
  logic        AXIS_TVALID;
  logic        AXIS_TREADY = 1'b1;
  logic [4:0]  AXIS_TUSER;

  logic [11:0] a_mem [64];
  logic [11:0] b_mem [128];

  int n_checks = 0, n_fail = 0, cyc = 0, rdy_mode = 0;
  logic [11:0] exp_d [$];
  logic [4:0]  exp_u [$];
  logic [11:0] rx_data [256];
  int          rx_n = 0, first_cyc = -1, last_cyc = 0, hs_cyc = 0;
  logic [4:0]  last_u = '0;
  bit          busy_chk = 0, prev_stall = 0, b_changed = 0;
  logic [11:0] prev_d = '0;
  logic [4:0]  prev_u = '0;
  logic [6:0]  b_ref = '0;

  mmm_stream_tx #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_k(cmd_k), .cmd_new_b(cmd_new_b), .cmd_err(cmd_err), .busy(busy),
    .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID),
    .AXIS_TUSER(AXIS_TUSER), .AXIS_TREADY(AXIS_TREADY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    a_rd_data <= a_mem[a_rd_addr];
    b_rd_data <= b_mem[b_rd_addr];
  end

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       AXIS_TREADY = 1'b1;
      1:       AXIS_TREADY = 1'($urandom_range(0, 1));
      default: AXIS_TREADY = 1'b0;
    endcase
  end

  // Stream checker: every valid beat must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("tvalid_in_reset", AXIS_TVALID, 0);
      exp_d.delete();
      exp_u.delete();
      prev_stall = 0;
      busy_chk = 0;
    end else begin
      if (busy_chk) begin
        chk("busy_fall", busy, 0);
        busy_chk = 0;
      end
      if (prev_stall) begin
        chk("hold_tvalid", AXIS_TVALID, 1);
        chk("hold_tdata", AXIS_TDATA, prev_d);
        chk("hold_tuser", AXIS_TUSER, prev_u);
      end
      if (AXIS_TVALID) begin
        if (exp_d.size() == 0) begin
          chk("stray_beat", AXIS_TVALID, 0);
        end else begin
          chk("tdata", AXIS_TDATA, exp_d[0]);
          chk("tuser", AXIS_TUSER, exp_u[0]);
        end
        if (first_cyc < 0) first_cyc = cyc;
        if (AXIS_TREADY) begin
          if (rx_n < 256) rx_data[rx_n] = AXIS_TDATA;
          rx_n++;
          last_cyc = cyc;
          last_u = AXIS_TUSER;
          if (exp_d.size() > 0) begin
            void'(exp_d.pop_front());
            void'(exp_u.pop_front());
            if (exp_d.size() == 0) busy_chk = 1;
          end
        end
      end
      prev_stall = AXIS_TVALID & !AXIS_TREADY;
      prev_d = AXIS_TDATA;
      prev_u = AXIS_TUSER;
      if (b_rd_addr != b_ref) b_changed = 1;
    end
  end

  task automatic send_cmd(input int k, input bit nb);
    int w = 0;
    @(posedge clk);
    #1;
    while (!cmd_ready && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_k = 4'(k);
    cmd_new_b = nb;
    rx_n = 0;
    first_cyc = -1;
    if (k >= 1 && k <= MAXK) begin
      for (int i = 0; i < M * k; i++) begin
        exp_d.push_back(a_mem[i]);
        exp_u.push_back(5'(2 * k + int'(nb)));
      end
      if (nb) begin
        for (int i = 0; i < k * N; i++) begin
          exp_d.push_back(b_mem[i]);
          exp_u.push_back(5'(2 * k + 1));
        end
      end
    end
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    @(negedge clk);
    while ((exp_d.size() != 0 || busy) && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("done_in_budget", (exp_d.size() == 0 && !busy), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int max_addr;
    int w;
    cmd_valid = 1'b0;
    cmd_k = '0;
    cmd_new_b = 1'b0;
    for (int i = 0; i < 64; i++) a_mem[i] = 12'(i);
    for (int i = 0; i < 128; i++) b_mem[i] = 12'(100 + i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", AXIS_TVALID, 0);
    chk("rst_tdata", AXIS_TDATA, 0);
    chk("rst_tuser", AXIS_TUSER, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a_addr", a_rd_addr, 0);
    chk("rst_b_addr", b_rd_addr, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // K=2 with B, full throughput
    send_cmd(2, 1);
    wait_done(300);
    chk("t1_beats", rx_n, 32);
    chk("t1_latency", first_cyc - hs_cyc, 2);
    chk("t1_contiguous", last_cyc - first_cyc, 31);
    chk("t1_first", rx_data[0], 0);
    chk("t1_last_a", rx_data[13], 13);
    chk("t1_first_b", rx_data[14], 100);
    chk("t1_last_b", rx_data[31], 117);
    chk("t1_tuser", last_u, 5);

    // K=8 without B
    b_ref = b_rd_addr;
    b_changed = 0;
    send_cmd(8, 0);
    wait_done(300);
    chk("t2_beats", rx_n, 56);
    chk("t2_last", rx_data[55], 55);
    chk("t2_tuser", last_u, 16);
    chk("t2_b_addr_still", b_changed, 0);

    // K=3 with B, random data and random backpressure
    for (int i = 0; i < 64; i++) a_mem[i] = 12'($urandom);
    for (int i = 0; i < 128; i++) b_mem[i] = 12'($urandom);
    rdy_mode = 1;
    send_cmd(3, 1);
    wait_done(2000);
    chk("t3_beats", rx_n, 48);
    rdy_mode = 0;

    // illegal K values
    send_cmd(0, 0);
    @(negedge clk);
    chk("k0_err", cmd_err, 1);
    chk("k0_busy", busy, 0);
    chk("k0_ready", cmd_ready, 1);
    @(negedge clk);
    chk("k0_err_once", cmd_err, 0);
    send_cmd(9, 1);
    @(negedge clk);
    chk("k9_err", cmd_err, 1);
    chk("k9_busy", busy, 0);
    chk("k9_tvalid", AXIS_TVALID, 0);
    @(negedge clk);
    chk("k9_err_once", cmd_err, 0);
    chk("k9_ready", cmd_ready, 1);

    // reset in the middle of a transfer
    send_cmd(4, 1);
    w = 0;
    while (rx_n < 10 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("t5_reach_10", rx_n >= 10, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_tvalid", AXIS_TVALID, 0);
    chk("t5_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_ready_after", cmd_ready, 1);
    send_cmd(1, 0);
    wait_done(200);
    chk("t5_k1_beats", rx_n, 7);
    chk("t5_k1_last", rx_data[6], a_mem[6]);

    // stalled sink at transfer start
    rdy_mode = 2;
    send_cmd(2, 0);
    max_addr = 0;
    repeat (20) begin
      @(negedge clk);
      if (int'(a_rd_addr) > max_addr) max_addr = int'(a_rd_addr);
    end
    chk("t6_reads_issued", max_addr, 1);
    chk("t6_tvalid_held", AXIS_TVALID, 1);
    chk("t6_tdata_head", AXIS_TDATA, a_mem[0]);
    rdy_mode = 0;
    wait_done(300);
    chk("t6_beats", rx_n, 14);
    chk("t6_last", rx_data[13], a_mem[13]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
